// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space-invaders video blocks.
// Holds screen geometry, colour codes, the laser draw state type, scanner
// counter widths and the on-screen test used by the optional clip build.
package space_invaders_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;

  // Counter widths cover the largest sprite: 8 columns, 4 rows.
  localparam int COL_CNT_W = 3;
  localparam int ROW_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FIN   = 2'd3
  } draw_state_t;

  // True when the unwrapped pixel coordinate lies inside the visible screen.
  function automatic logic on_screen(input logic [8:0] ux, input logic [7:0] uy);
    return (ux < 9'(SCREEN_W)) && (uy < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/laser_draw_rect_scanner.sv
// rect_scanner: walks a W x H rectangle one pixel per advance, column
// fastest. o_last flags the final pixel so the caller can change phase.
// The same instance serves both the erase and the draw phase.
import space_invaders_pkg::*;

module rect_scanner #(
  parameter int W = 4,
  parameter int H = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_advance,
  output logic [COL_CNT_W-1:0] o_col,
  output logic [ROW_CNT_W-1:0] o_row,
  output logic                 o_last
);

  localparam logic [COL_CNT_W-1:0] COL_MAX = COL_CNT_W'(W - 1);
  localparam logic [ROW_CNT_W-1:0] ROW_MAX = ROW_CNT_W'(H - 1);

  logic [COL_CNT_W-1:0] r_col;
  logic [ROW_CNT_W-1:0] r_row;

  // Column/row counters: clear wins over advance; wrap at the rectangle edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_col <= 3'd0;
      r_row <= 2'd0;
    end else if (i_clear) begin
      r_col <= 3'd0;
      r_row <= 2'd0;
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        r_col <= 3'd0;
        if (r_row == ROW_MAX) begin
          r_row <= 2'd0;
        end else begin
          r_row <= r_row + 2'd1;
        end
      end else begin
        r_col <= r_col + 3'd1;
      end
    end else begin
      r_col <= r_col;
      r_row <= r_row;
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/laser_draw.sv
// laser_draw: on each frame tick, erases the laser sprite at its previous
// position and redraws it at the newly latched one through the VGA plot port.
// All outputs are registered, so every phase shows up one cycle after the
// state that produces it. Build option LASER_DRAW_CLIP_EN suppresses the
// write strobe for pixels that fall off the 160x120 screen (scan timing is
// unchanged); without it coordinates wrap modulo 256/128.
module laser_draw
  import space_invaders_pkg::*;
#(
  parameter int         W      = 4,
  parameter int         H      = 1,
  parameter logic [2:0] COLOUR = COL_RED
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       active,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  draw_state_t r_state;
  draw_state_t w_next_state;

  logic [7:0] r_prev_x;
  logic [6:0] r_prev_y;
  logic       r_prev_valid;
  logic [7:0] r_new_x;
  logic [6:0] r_new_y;
  logic       r_new_act;

  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour;
  logic       r_vga_plot;
  logic       r_busy;
  logic       r_done;

  logic                 w_accept;
  logic                 w_update;
  logic                 w_scan_clear;
  logic                 w_scan_adv;
  logic [COL_CNT_W-1:0] w_col;
  logic [ROW_CNT_W-1:0] w_row;
  logic                 w_last;
  logic [7:0]           w_base_x;
  logic [6:0]           w_base_y;
  logic [7:0]           w_pix_x;
  logic [6:0]           w_pix_y;
  logic                 w_onscreen;
  logic [7:0]           w_x;
  logic [6:0]           w_y;
  logic [2:0]           w_colour;
  logic                 w_plot;
  logic                 w_busy;
  logic                 w_done;

  rect_scanner #(
    .W (W),
    .H (H)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_scan_clear),
    .i_advance (w_scan_adv),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_last    (w_last)
  );

  // Rectangle origin: erase walks the old position, draw walks the new one.
  always_comb begin
    w_base_x = r_prev_x;
    w_base_y = r_prev_y;
    if (r_state == ST_DRAW) begin
      w_base_x = r_new_x;
      w_base_y = r_new_y;
    end else begin
      w_base_x = r_prev_x;
      w_base_y = r_prev_y;
    end
  end

`ifdef LASER_DRAW_CLIP_EN
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  assign w_sum_x    = {1'b0, w_base_x} + {6'd0, w_col};
  assign w_sum_y    = {1'b0, w_base_y} + {6'd0, w_row};
  assign w_pix_x    = w_sum_x[7:0];
  assign w_pix_y    = w_sum_y[6:0];
  assign w_onscreen = on_screen(w_sum_x, w_sum_y);
`else
  assign w_pix_x    = w_base_x + {5'd0, w_col};
  assign w_pix_y    = w_base_y + {5'd0, w_row};
  assign w_onscreen = 1'b1;
`endif

  // Next-state and pre-register output decode; defaults keep the FSM idle.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_update     = 1'b0;
    w_scan_clear = 1'b0;
    w_scan_adv   = 1'b0;
    w_x          = 8'd0;
    w_y          = 7'd0;
    w_colour     = COL_BLACK;
    w_plot       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_busy is still high during the done cycle; a tick there is dropped.
        if (start && !r_busy) begin
          w_accept     = 1'b1;
          w_scan_clear = 1'b1;
          if (r_prev_valid) begin
            w_next_state = ST_ERASE;
          end else if (active) begin
            w_next_state = ST_DRAW;
          end else begin
            w_next_state = ST_FIN;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ERASE: begin
        w_busy   = 1'b1;
        w_x      = w_pix_x;
        w_y      = w_pix_y;
        w_colour = COL_BLACK;
        w_plot   = w_onscreen;
        if (w_last) begin
          w_scan_clear = 1'b1;
          w_next_state = r_new_act ? ST_DRAW : ST_FIN;
        end else begin
          w_scan_adv = 1'b1;
        end
      end
      ST_DRAW: begin
        w_busy   = 1'b1;
        w_x      = w_pix_x;
        w_y      = w_pix_y;
        w_colour = COLOUR;
        w_plot   = w_onscreen;
        if (w_last) begin
          w_scan_clear = 1'b1;
          w_next_state = ST_FIN;
        end else begin
          w_scan_adv = 1'b1;
        end
      end
      ST_FIN: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_update     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the requested position once per accepted tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_new_x   <= 8'd0;
      r_new_y   <= 7'd0;
      r_new_act <= 1'b0;
    end else if (w_accept) begin
      r_new_x   <= x_pos;
      r_new_y   <= y_pos;
      r_new_act <= active;
    end else begin
      r_new_x   <= r_new_x;
      r_new_y   <= r_new_y;
      r_new_act <= r_new_act;
    end
  end

  // Remember what is on screen now so the next pass knows what to erase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev_x     <= 8'd0;
      r_prev_y     <= 7'd0;
      r_prev_valid <= 1'b0;
    end else if (w_update) begin
      r_prev_x     <= r_new_x;
      r_prev_y     <= r_new_y;
      r_prev_valid <= r_new_act;
    end else begin
      r_prev_x     <= r_prev_x;
      r_prev_y     <= r_prev_y;
      r_prev_valid <= r_prev_valid;
    end
  end

  // Output register stage driving the VGA adapter and handshake lines.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_vga_x      <= w_x;
      r_vga_y      <= w_y;
      r_vga_colour <= w_colour;
      r_vga_plot   <= w_plot;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_laser_draw.sv
// Self-checking bench for laser_draw. The stimulus side computes the full
// list of expected plots and the done pulse for each pass (with the cycle
// each must appear in) from the sprite rules and pushes them to a queue; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_laser_draw;

  localparam int         W      = 4;
  localparam int         H      = 1;
  localparam logic [2:0] COLOUR = 3'b100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       active;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  laser_draw #(.W(W), .H(H), .COLOUR(COLOUR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .active     (active),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    int         cyc;
  } item_t;

  item_t q[$];
  int    cyc       = 0;
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    win_start = 1;
  int    win_end   = 0;
  bit    mon_en    = 1'b0;

  // Reference state: what the sprite currently looks like on screen.
  logic [7:0] m_px;
  logic [6:0] m_py;
  bit         m_pv = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One rectangle: column fastest, unwrapped sums, optional clip.
  task automatic push_rect(input int bx, input int by, input logic [2:0] col,
                           input int first_cyc, inout int n);
    item_t it;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int ux = bx + c;
        int uy = by + r;
        bit keep = 1'b1;
`ifdef LASER_DRAW_CLIP_EN
        if (ux >= 160 || uy >= 120) keep = 1'b0;
`endif
        if (keep) begin
          it.is_done = 1'b0;
          it.x       = 8'(ux % 256);
          it.y       = 7'(uy % 128);
          it.col     = col;
          it.cyc     = first_cyc + n;
          q.push_back(it);
        end
        n++;
      end
    end
  endtask

  // Issue one frame tick; optionally re-pulse start or reset during the pass.
  // restart_at / reset_at name the first cycle the event can affect (0 = none).
  task automatic run_pass(input bit act, input logic [7:0] x, input logic [6:0] y,
                          input int restart_at, input int reset_at);
    int    e;
    int    n = 0;
    bit    aborted = 1'b0;
    item_t it;
    start  = 1'b1;
    active = act;
    x_pos  = x;
    y_pos  = y;
    e      = cyc + 1;
    if (m_pv) push_rect(int'(m_px), int'(m_py), 3'b000, e + 1, n);
    if (act)  push_rect(int'(x), int'(y), COLOUR, e + 1, n);
    it.is_done = 1'b1;
    it.x = 8'd0; it.y = 7'd0; it.col = 3'd0;
    it.cyc = e + n + 1;
    q.push_back(it);
    win_start = e + 1;
    win_end   = e + n + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + n + 2 && !aborted) begin
      start  = (restart_at != 0) && (cyc == e + restart_at - 1);
      x_pos  = 8'($urandom);
      y_pos  = 7'($urandom);
      active = 1'($urandom);
      if (reset_at != 0 && cyc == e + reset_at - 1) begin
        reset_n = 1'b0;
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        if (win_end > cyc) win_end = cyc;
        aborted = 1'b1;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    reset_n = 1'b1;
    if (aborted) begin
      m_pv = 1'b0;
    end else begin
      m_px = x;
      m_py = y;
      m_pv = act;
    end
  endtask

  // Monitor: compare every plot/done the DUT shows against the queue head.
  always @(negedge clk) begin
    item_t it;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk(1'b0, "missed_output", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (vga_plot || done) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk(1'b0, "unexpected_output", {vga_plot, done}, 0);
        end else begin
          it = q.pop_front();
          chk(done == it.is_done, "done", int'(done), int'(it.is_done));
          chk(vga_plot == !it.is_done, "plot", int'(vga_plot), int'(!it.is_done));
          if (!it.is_done) begin
            chk(vga_x == it.x, "vga_x", int'(vga_x), int'(it.x));
            chk(vga_y == it.y, "vga_y", int'(vga_y), int'(it.y));
            chk(vga_colour == it.col, "vga_colour", int'(vga_colour), int'(it.col));
          end
        end
      end
      chk(busy == (cyc >= win_start && cyc <= win_end), "busy",
          int'(busy), int'(cyc >= win_start && cyc <= win_end));
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    active  = 1'b0;
    x_pos   = 8'd0;
    y_pos   = 7'd0;
    repeat (3) @(negedge clk);
    chk(vga_plot == 1'b0, "reset_plot", int'(vga_plot), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(vga_x == 8'd0, "reset_x", int'(vga_x), 0);
    chk(vga_y == 7'd0, "reset_y", int'(vga_y), 0);
    chk(vga_colour == 3'd0, "reset_colour", int'(vga_colour), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Draw only, then erase+draw, then erase only, then nothing to do.
    run_pass(1'b1, 8'd155, 7'd10, 0, 0);
    run_pass(1'b1, 8'd150, 7'd10, 0, 0);
    run_pass(1'b0, 8'd7, 7'd7, 0, 0);
    run_pass(1'b0, 8'd9, 7'd9, 0, 0);
    // Start re-pulsed in cycle 3 of a pass is ignored.
    run_pass(1'b1, 8'd20, 7'd30, 0, 0);
    run_pass(1'b1, 8'd40, 7'd50, 3, 0);
    // Reset asserted during cycle 2 of an erase pass, then a draw-only pass.
    run_pass(1'b1, 8'd60, 7'd70, 0, 3);
    run_pass(1'b1, 8'd80, 7'd90, 0, 0);
    // Right-edge sprite: clipped or wrapped depending on the build.
    run_pass(1'b1, 8'd158, 7'd5, 0, 0);
    run_pass(1'b1, 8'd250, 7'd126, 0, 0);

    for (int i = 0; i < 60; i++) begin
      bit         a  = ($urandom_range(0, 3) != 0);
      logic [7:0] rx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom);
      logic [6:0] ry = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom);
      int         rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      int         rr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      run_pass(a, rx, ry, rs, rr);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
